riscv_core_div_ctrl: RTL

- Initiator for the sequential unsigned non-restoring divider; RV64M DIV/DIVU/REM/REMU and the W variants issue through this block.
- Accepts one operation from execute over a valid/ready handshake and prepares unsigned magnitudes.
- Short-circuits divide-by-zero and signed overflow; otherwise pulses the divider start and waits for its done.
- Applies sign and word fix-up, then holds the result until writeback accepts it.

---
 rtl/riscv_core_div_pkg.sv | 38 +++
 rtl/riscv_core_div_fixup.sv | 30 +++
 rtl/riscv_core_div_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/riscv_core_div_pkg.sv
// Shared types and helpers for the RV64M divide controller.
package riscv_core_div_pkg;

   // Widest operand the helpers handle. Narrower XLEN values are cast in and out.
   localparam int unsigned DIV_MAX_XLEN = 64;

   typedef enum logic [1:0] {
      DIV_OP_DIV  = 2'd0,
      DIV_OP_DIVU = 2'd1,
      DIV_OP_REM  = 2'd2,
      DIV_OP_REMU = 2'd3
   } div_op_e;

   typedef enum logic [2:0] {
      DIV_IDLE,
      DIV_ISSUE,
      DIV_WAIT,
      DIV_RESP,
      DIV_DRAIN
   } div_state_e;

   // Conditional two's-complement negation. Used both for taking magnitudes
   // and for re-applying signs; the most-negative value maps to itself,
   // which read as unsigned is 2^(XLEN-1).
   function automatic logic [DIV_MAX_XLEN-1:0] abs_xlen(input logic [DIV_MAX_XLEN-1:0] val,
                                                        input logic                    neg);
      return neg ? (-val) : val;
   endfunction

   function automatic logic is_signed_op(input div_op_e op);
      return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
   endfunction

   function automatic logic is_rem_op(input div_op_e op);
      return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
   endfunction

endpackage

// File: rtl/riscv_core_div_fixup.sv
// Sign and word fix-up of a raw quotient/remainder into the final result.
module riscv_core_div_fixup
   import riscv_core_div_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  div_op_e          i_op,
   input  logic             i_word,
   input  logic             i_quot_neg,
   input  logic             i_rem_neg,
   input  logic [XLEN-1:0]  i_quot,
   input  logic [XLEN-1:0]  i_rem,
   output logic [XLEN-1:0]  o_result
);

   logic            is_rem;
   logic            neg;
   logic [XLEN-1:0] raw;
   logic [XLEN-1:0] val;

   // Select quotient or remainder, re-apply the sign, then word sign-extend.
   always_comb begin
      is_rem   = is_rem_op(i_op);
      neg      = is_signed_op(i_op) & (is_rem ? i_rem_neg : i_quot_neg);
      raw      = is_rem ? i_rem : i_quot;
      val      = XLEN'(abs_xlen(DIV_MAX_XLEN'(raw), neg));
      o_result = i_word ? {{(XLEN-32){val[31]}}, val[31:0]} : val;
   end

endmodule

// File: rtl/riscv_core_div_ctrl.sv
// Issue/response controller in front of the sequential non-restoring divider.
module riscv_core_div_ctrl
   import riscv_core_div_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic             i_non_restoring_clk,
   input  logic             i_non_restoring_rstn,
   input  logic             i_div_valid,
   output logic             o_div_ready,
   input  logic [1:0]       i_div_op,
   input  logic             i_div_word,
   input  logic [XLEN-1:0]  i_div_rs1,
   input  logic [XLEN-1:0]  i_div_rs2,
   input  logic             i_div_flush,
   output logic             o_div_result_valid,
   input  logic             i_div_result_ready,
   output logic [XLEN-1:0]  o_div_result,
   output logic             o_non_restoring_en,
   output logic [XLEN-1:0]  o_non_restoring_dividend,
   output logic [XLEN-1:0]  o_non_restoring_divisor,
   input  logic             i_non_restoring_done,
   input  logic [XLEN-1:0]  i_non_restoring_quotient,
   input  logic [XLEN-1:0]  i_non_restoring_remainder
);

   div_state_e      state_q, state_d;
   div_op_e         op_q, op_d;
   logic            word_q, word_d;
   logic            quot_neg_q, quot_neg_d;
   logic            rem_neg_q, rem_neg_d;
   logic [XLEN-1:0] dividend_q, dividend_d;
   logic [XLEN-1:0] divisor_q, divisor_d;
   logic [XLEN-1:0] result_q, result_d;

   div_op_e         op_in;
   logic            signed_in, sign1, sign2;
   logic            div_zero, min_dividend, overflow, shortcut;
   logic [XLEN-1:0] rs1_ext, rs2_ext, mag1, mag2, sc_quot, sc_rem;

   div_op_e         fx_op;
   logic            fx_word, fx_quot_neg, fx_rem_neg;
   logic [XLEN-1:0] fx_quot, fx_rem, fx_result;

   // Operand preparation: width extension, signs, magnitudes and shortcut detection.
   always_comb begin
      op_in     = div_op_e'(i_div_op);
      signed_in = is_signed_op(op_in);
      rs1_ext   = i_div_word ? {{(XLEN-32){signed_in & i_div_rs1[31]}}, i_div_rs1[31:0]} : i_div_rs1;
      rs2_ext   = i_div_word ? {{(XLEN-32){signed_in & i_div_rs2[31]}}, i_div_rs2[31:0]} : i_div_rs2;
      sign1     = signed_in & rs1_ext[XLEN-1];
      sign2     = signed_in & rs2_ext[XLEN-1];
      mag1      = XLEN'(abs_xlen(DIV_MAX_XLEN'(rs1_ext), sign1));
      mag2      = XLEN'(abs_xlen(DIV_MAX_XLEN'(rs2_ext), sign2));
      div_zero  = (rs2_ext == '0);
      min_dividend = i_div_word ? (rs1_ext[31:0] == 32'h8000_0000)
                                : (rs1_ext == {1'b1, {(XLEN-1){1'b0}}});
      overflow  = signed_in & min_dividend & (rs2_ext == '1);
      shortcut  = div_zero | overflow;
      sc_quot   = div_zero ? '1 : rs1_ext;
      sc_rem    = div_zero ? rs1_ext : '0;
   end

   // Shared fix-up: shortcut values (already signed, so no negation) while idle,
   // divider outputs with the registered signs otherwise.
   always_comb begin
      if (state_q == DIV_IDLE) begin
         fx_op       = op_in;
         fx_word     = i_div_word;
         fx_quot_neg = 1'b0;
         fx_rem_neg  = 1'b0;
         fx_quot     = sc_quot;
         fx_rem      = sc_rem;
      end else begin
         fx_op       = op_q;
         fx_word     = word_q;
         fx_quot_neg = quot_neg_q;
         fx_rem_neg  = rem_neg_q;
         fx_quot     = i_non_restoring_quotient;
         fx_rem      = i_non_restoring_remainder;
      end
   end

   riscv_core_div_fixup #(
      .XLEN(XLEN)
   ) u_fixup (
      .i_op       (fx_op),
      .i_word     (fx_word),
      .i_quot_neg (fx_quot_neg),
      .i_rem_neg  (fx_rem_neg),
      .i_quot     (fx_quot),
      .i_rem      (fx_rem),
      .o_result   (fx_result)
   );

   // Next-state and register updates for the issue/response FSM.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      word_d     = word_q;
      quot_neg_d = quot_neg_q;
      rem_neg_d  = rem_neg_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      result_d   = result_q;
      case (state_q)
         DIV_IDLE: begin
            if (i_div_valid && !i_div_flush) begin
               op_d       = op_in;
               word_d     = i_div_word;
               quot_neg_d = sign1 ^ sign2;
               rem_neg_d  = sign1;
               dividend_d = mag1;
               divisor_d  = mag2;
               if (shortcut) begin
                  result_d = fx_result;
                  state_d  = DIV_RESP;
               end else begin
                  state_d  = DIV_ISSUE;
               end
            end
         end
         DIV_ISSUE: state_d = i_div_flush ? DIV_DRAIN : DIV_WAIT;
         DIV_WAIT: begin
            if (i_div_flush) begin
               state_d = i_non_restoring_done ? DIV_IDLE : DIV_DRAIN;
            end else if (i_non_restoring_done) begin
               result_d = fx_result;
               state_d  = DIV_RESP;
            end
         end
         DIV_RESP: begin
            if (i_div_flush || i_div_result_ready) state_d = DIV_IDLE;
         end
         DIV_DRAIN: begin
            if (i_non_restoring_done) state_d = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   // State and operand registers.
   always_ff @(posedge i_non_restoring_clk or negedge i_non_restoring_rstn) begin
      if (!i_non_restoring_rstn) begin
         state_q    <= DIV_IDLE;
         op_q       <= DIV_OP_DIV;
         word_q     <= 1'b0;
         quot_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         word_q     <= word_d;
         quot_neg_q <= quot_neg_d;
         rem_neg_q  <= rem_neg_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         result_q   <= result_d;
      end
   end

   assign o_div_ready              = (state_q == DIV_IDLE);
   assign o_div_result_valid       = (state_q == DIV_RESP);
   assign o_div_result             = result_q;
   assign o_non_restoring_en       = (state_q == DIV_ISSUE);
   assign o_non_restoring_dividend = dividend_q;
   assign o_non_restoring_divisor  = divisor_q;

endmodule
